// File: rtl/sc_rr_sched.sv
// Round-robin owner scheduler for a shared 3-bit saturating step counter used as a time-slice timer.
// Optional macro SC_SCHED_PRIO_EN makes requester 0 high priority (pre-empts other owners).
module sc_rr_sched #(
    parameter int unsigned N       = 4,
    parameter int unsigned MAX_CNT = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic [2:0]   cnt,
    output logic         ctr_rst,
    output logic [N-1:0] gnt,
    output logic         busy,
    output logic         err
);

    localparam int unsigned PtrW   = $clog2(N);
    localparam logic [2:0]  MaxCnt = 3'(MAX_CNT);

    typedef enum logic [1:0] {StIdle, StGrant, StSwitch} state_e;

    state_e          state_q, state_d;
    logic [PtrW-1:0] ptr_q, ptr_d;
    logic [PtrW-1:0] owner_q, owner_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic            busy_q, busy_d;
    logic            ctr_rst_q, ctr_rst_d;
    logic            err_q, err_d;
    logic            first_q, first_d;

    logic            pick_found;
    logic [PtrW-1:0] pick_idx;
    logic            owner_req, others_req, slice_done, preempt, err_seen;

    // base and off are both below N, so one conditional subtract is enough (N need not be 2^k).
    function automatic logic [PtrW-1:0] rr_idx(input logic [PtrW-1:0] base,
                                               input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= N) sum = sum - N;
        return PtrW'(sum);
    endfunction

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!pick_found && req[rr_idx(ptr_q, i)]) begin
                pick_found = 1'b1;
                pick_idx   = rr_idx(ptr_q, i);
            end
        end
`ifdef SC_SCHED_PRIO_EN
        if (req[0]) begin
            pick_found = 1'b1;
            pick_idx   = '0;
        end
`endif
    end

    always_comb begin
        owner_req  = |(req & gnt_q);
        others_req = |(req & ~gnt_q);
        slice_done = (cnt == MaxCnt) && others_req;
`ifdef SC_SCHED_PRIO_EN
        preempt    = req[0] && !gnt_q[0];
`else
        preempt    = 1'b0;
`endif
        // A nonzero count in the first grant cycle means the counter missed our clear.
        err_seen   = (cnt > MaxCnt) || ((state_q == StGrant) && first_q && (cnt != 3'd0));
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        gnt_d     = gnt_q;
        ctr_rst_d = ctr_rst_q;
        first_d   = 1'b0;
        err_d     = err_q | err_seen;
        unique case (state_q)
            StIdle, StSwitch: begin
                state_d   = StIdle;
                gnt_d     = '0;
                ctr_rst_d = 1'b1;
                if (pick_found) begin
                    state_d         = StGrant;
                    owner_d         = pick_idx;
                    gnt_d[pick_idx] = 1'b1;
                    ctr_rst_d       = 1'b0;
                    first_d         = 1'b1;
                end
            end
            StGrant: begin
                ctr_rst_d = 1'b0;
                if (!owner_req || slice_done || preempt) begin
                    state_d   = StSwitch;
                    gnt_d     = '0;
                    ctr_rst_d = 1'b1;
                    ptr_d     = (owner_q == PtrW'(N - 1)) ? '0 : owner_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = |gnt_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            owner_q   <= '0;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            ctr_rst_q <= 1'b1;
            err_q     <= 1'b0;
            first_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            ctr_rst_q <= ctr_rst_d;
            err_q     <= err_d;
            first_q   <= first_d;
        end
    end

    assign gnt     = gnt_q;
    assign busy    = busy_q;
    assign ctr_rst = ctr_rst_q;
    assign err     = err_q;

endmodule
